counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 135 +++++++++++++
 tb/tb_counter_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer
//  Purpose  : Two-requester round-robin sequencer that grants a shared 8-bit
//             counter for a requester-specified run length (0 encodes 256).
//             Optional abort support is enabled by defining CNTSEQ_ABORT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module counter_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] len0,
    input  logic [7:0] len1,
`ifdef CNTSEQ_ABORT_EN
    input  logic       abort,
    output logic       aborted,
`endif
    output logic [1:0] gnt,
    output logic       busy,
    output logic [7:0] count,
    output logic       done,
    output logic       done_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] w_count_nxt;
    logic [7:0] r_len_q;
    logic [7:0] w_len_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_rr;
    logic       w_rr_nxt;
    logic       w_sel;
    logic       w_abort_req;
    logic       w_last;
    logic [7:0] w_len_m1;

`ifdef CNTSEQ_ABORT_EN
    logic       r_aborted;
    logic       w_aborted_nxt;
    assign w_abort_req = abort;
    assign aborted     = r_aborted;
`else
    assign w_abort_req = 1'b0;
`endif

    // Simultaneous requests go to the favoured requester, otherwise the sole one.
    assign w_sel    = (req == 2'b11) ? r_rr : req[1];
    // 8-bit wrap makes len_q=0 terminate at count=255, i.e. a 256-cycle run.
    assign w_len_m1 = r_len_q - 8'd1;
    assign w_last   = (r_count == w_len_m1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= 8'd0;
            r_len_q <= 8'd0;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_len_q <= w_len_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

`ifdef CNTSEQ_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_aborted_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_len_nxt   = r_len_q;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
`ifdef CNTSEQ_ABORT_EN
        w_aborted_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_count_nxt = 8'd0;
                if (req != 2'b00) begin
                    w_owner_nxt = w_sel;
                    w_len_nxt   = w_sel ? len1 : len0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort_req || w_last) begin
                    w_state_nxt = S_DONE;
                    w_rr_nxt    = ~r_owner;
`ifdef CNTSEQ_ABORT_EN
                    w_aborted_nxt = w_abort_req;
`endif
                end else begin
                    w_count_nxt = r_count + 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 8'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = 8'd0;
            end
        endcase
    end

    assign gnt     = (r_state == S_RUN) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy    = (r_state == S_RUN) || (r_state == S_DONE);
    assign done    = (r_state == S_DONE);
    assign done_id = (r_state == S_DONE) && r_owner;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequencer
//  Purpose  : Directed table-driven bench for counter_sequencer, plus
//             hand-written multi-cycle sequences (wrap run, mid-run reset,
//             abort when CNTSEQ_ABORT_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [7:0] len0;
    logic [7:0] len1;
    logic       abort;
    logic       aborted;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] count;
    logic       done;
    logic       done_id;

    int n_checks = 0;
    int n_pass   = 0;

    counter_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
`ifdef CNTSEQ_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .gnt     (gnt),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [7:0] len0;
        logic [7:0] len1;
        logic [1:0] gnt;
        logic       busy;
        logic [7:0] count;
        logic       done;
        logic       done_id;
    } vec_t;

    vec_t vq[$];

    function void add(input logic r, input logic [1:0] rq, input logic [7:0] l0,
                      input logic [7:0] l1, input logic [1:0] g, input logic b,
                      input logic [7:0] c, input logic d, input logic id);
        vec_t v;
        v.rst = r; v.req = rq; v.len0 = l0; v.len1 = l1;
        v.gnt = g; v.busy = b; v.count = c; v.done = d; v.done_id = id;
        vq.push_back(v);
    endfunction

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] g, input logic b,
                         input logic [7:0] c, input logic d, input logic id);
        n_checks++;
        if ({gnt, busy, count, done, done_id} === {g, b, c, d, id}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b busy=%b count=%0d done=%b done_id=%b, want gnt=%b busy=%b count=%0d done=%b done_id=%b",
                     name, gnt, busy, count, done, done_id, g, b, c, d, id);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; len0 = 8'd0; len1 = 8'd0; abort = 1'b0;

        // Reset, single run of 4 by requester 0 with ignored mid-run input changes.
        add(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        add(1, 2'b01, 4, 0, 2'b01, 1, 0, 0, 0);
        add(1, 2'b00, 9, 0, 2'b01, 1, 1, 0, 0);
        add(1, 2'b00, 9, 0, 2'b01, 1, 2, 0, 0);
        add(1, 2'b10, 9, 7, 2'b01, 1, 3, 0, 0);
        add(1, 2'b10, 9, 7, 2'b00, 1, 3, 1, 0);
        add(1, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0);
        // rr=1 now: sole requester 0 still wins; length 1.
        add(1, 2'b01, 1, 0, 2'b01, 1, 0, 0, 0);
        add(1, 2'b00, 1, 0, 2'b00, 1, 0, 1, 0);
        add(1, 2'b00, 1, 0, 2'b00, 0, 0, 0, 0);
        // rr=1 with both requesting: requester 1 wins.
        add(1, 2'b11, 5, 1, 2'b10, 1, 0, 0, 0);
        add(1, 2'b00, 5, 1, 2'b00, 1, 0, 1, 1);
        add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
        // Reset, then req=11 held with len0=2, len1=3.
        add(0, 2'b11, 2, 3, 2'b00, 0, 0, 0, 0);
        add(1, 2'b11, 2, 3, 2'b01, 1, 0, 0, 0);
        add(1, 2'b11, 2, 3, 2'b01, 1, 1, 0, 0);
        add(1, 2'b11, 2, 3, 2'b00, 1, 1, 1, 0);
        add(1, 2'b11, 2, 3, 2'b00, 0, 0, 0, 0);
        add(1, 2'b11, 2, 3, 2'b10, 1, 0, 0, 0);
        add(1, 2'b11, 2, 3, 2'b10, 1, 1, 0, 0);
        add(1, 2'b11, 2, 3, 2'b10, 1, 2, 0, 0);
        add(1, 2'b11, 2, 3, 2'b00, 1, 2, 1, 1);
        add(1, 2'b11, 2, 3, 2'b00, 0, 0, 0, 0);
        add(1, 2'b11, 2, 3, 2'b01, 1, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; req = vq[i].req; len0 = vq[i].len0; len1 = vq[i].len1;
            step();
            check($sformatf("vec%0d", i), vq[i].gnt, vq[i].busy, vq[i].count,
                  vq[i].done, vq[i].done_id);
        end

        // 256-cycle run by requester 1 (len1=0), no early exit on wrap.
        rst = 1'b0; req = 2'b00;
        step();
        check("rst_before_wrap", 2'b00, 0, 0, 0, 0);
        rst = 1'b1; req = 2'b10; len1 = 8'd0;
        step();
        check("wrap_start", 2'b10, 1, 0, 0, 0);
        req = 2'b00; len1 = 8'd5;
        for (int k = 1; k < 256; k++) begin
            step();
            check($sformatf("wrap_cnt%0d", k), 2'b10, 1, k[7:0], 0, 0);
        end
        step();
        check("wrap_done", 2'b00, 1, 8'd255, 1, 1);
        step();
        check("wrap_idle", 2'b00, 0, 0, 0, 0);

        // Run by requester 0 sets rr=1 so the later reset must restore rr=0.
        req = 2'b01; len0 = 8'd1;
        step();
        check("rr_prep_run", 2'b01, 1, 0, 0, 0);
        req = 2'b00;
        step();
        check("rr_prep_done", 2'b00, 1, 0, 1, 0);
        step();
        check("rr_prep_idle", 2'b00, 0, 0, 0, 0);

        // Reset mid-run at count=5.
        req = 2'b01; len0 = 8'd10;
        step();
        check("midrst_cnt0", 2'b01, 1, 0, 0, 0);
        req = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("midrst_cnt%0d", k), 2'b01, 1, k[7:0], 0, 0);
        end
        rst = 1'b0;
        step();
        check("midrst_zero", 2'b00, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        check("midrst_no_done", 2'b00, 0, 0, 0, 0);
        req = 2'b11; len0 = 8'd2; len1 = 8'd4;
        step();
        check("midrst_rr0", 2'b01, 1, 0, 0, 0);

`ifdef CNTSEQ_ABORT_EN
        rst = 1'b0; req = 2'b00;
        step();
        check("ab_rst", 2'b00, 0, 0, 0, 0);
        check_bit("ab_rst_aborted", aborted, 1'b0);
        rst = 1'b1; req = 2'b01; len0 = 8'd10;
        step();
        check("ab_cnt0", 2'b01, 1, 0, 0, 0);
        req = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("ab_cnt%0d", k), 2'b01, 1, k[7:0], 0, 0);
        end
        abort = 1'b1;
        step();
        check("ab_done", 2'b00, 1, 3, 1, 0);
        check_bit("ab_aborted", aborted, 1'b1);
        step();
        check("ab_idle", 2'b00, 0, 0, 0, 0);
        check_bit("ab_aborted_clr", aborted, 1'b0);
        req = 2'b11;
        step();
        check("ab_rr1", 2'b10, 1, 0, 0, 0);
        check_bit("ab_idle_ignored", aborted, 1'b0);
        abort = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
